log_trig_lut_arbiter: RTL and testbench

- Round-robin arbiter and pipeline sequencer that time-shares one combinational quarter-wave log-sin/log-cos LUT between NREQ requesters, e.g. the FLAF tap expansion units.
- Each requester presents a 6-bit phase index (0..32) with a valid/ready handshake.
- The block registers the index, drives the shared LUT address, captures both log outputs, and returns a tagged response with backpressure.
- Throughput is one lookup per cycle when not stalled.

---
 rtl/log_trig_lut_arbiter.sv | 142 ++++++++++++++
 tb/tb_log_trig_lut_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/log_trig_lut_arbiter.sv
// Round-robin arbiter and two-stage sequencer sharing one combinational
// log-sin/log-cos LUT between NREQ requesters, with tagged, backpressured responses.
module log_trig_lut_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2,
  parameter int AMAX = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [6*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [5:0]        lut_addr,
  input  logic [15:0]       lut_logsin,
  input  logic [15:0]       lut_logcos,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_logsin,
  output logic [15:0]       rsp_logcos,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [5:0]     AMAX_IDX = 6'(AMAX);
  localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           v1_q, v1_d;
  logic [IDW-1:0] id1_q, id1_d;
  logic [5:0]     addr1_q, addr1_d;
  logic           err1_q, err1_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    rsp_logsin_q, rsp_logsin_d;
  logic [15:0]    rsp_logcos_q, rsp_logcos_d;
  logic           rsp_err_q, rsp_err_d;

  logic           adv;
  logic           any_hi, any_lo, any_valid, handshake;
  logic [IDW-1:0] hi_id, lo_id, grant_id;
  logic [NREQ-1:0] grant_oh;
  logic [5:0]     grant_addr;

  assign adv = !rsp_valid_q || rsp_ready;

  // Priority scan split into the requesters above the pointer and those at or
  // below it, so every index stays a constant after unrolling.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    any_hi     = 1'b0;
    any_lo     = 1'b0;
    hi_id      = '0;
    lo_id      = '0;
    grant_oh   = '0;
    grant_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_hi && req_valid[i] && (IDW'(i) > ptr_q)) begin
        any_hi = 1'b1;
        hi_id  = IDW'(i);
      end
      if (!any_lo && req_valid[i] && (IDW'(i) <= ptr_q)) begin
        any_lo = 1'b1;
        lo_id  = IDW'(i);
      end
    end
    any_valid = any_hi || any_lo;
    grant_id  = any_hi ? hi_id : lo_id;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = (IDW'(i) == grant_id);
      if (IDW'(i) == grant_id) grant_addr = req_addr[6*i +: 6];
    end
  end

  assign req_ready = (adv && any_valid && !rst) ? grant_oh : '0;
  assign handshake = |(req_valid & req_ready);

  always_comb begin
    ptr_d        = ptr_q;
    v1_d         = v1_q;
    id1_d        = id1_q;
    addr1_d      = addr1_q;
    err1_d       = err1_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_logsin_d = rsp_logsin_q;
    rsp_logcos_d = rsp_logcos_q;
    rsp_err_d    = rsp_err_q;
    if (handshake) ptr_d = grant_id;
    if (adv) begin
      v1_d        = handshake;
      id1_d       = grant_id;
      addr1_d     = grant_addr;
      err1_d      = (grant_addr > AMAX_IDX);
      rsp_valid_d = v1_q;
      // Data fields only move when a real lookup arrives; bubbles leave them intact.
      if (v1_q) begin
        rsp_id_d     = id1_q;
        rsp_err_d    = err1_q;
        rsp_logsin_d = err1_q ? 16'h0000 : lut_logsin;
        rsp_logcos_d = err1_q ? 16'h0000 : lut_logcos;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= PTR_RST;
      v1_q         <= 1'b0;
      id1_q        <= '0;
      addr1_q      <= '0;
      err1_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_logsin_q <= '0;
      rsp_logcos_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      v1_q         <= v1_d;
      id1_q        <= id1_d;
      addr1_q      <= addr1_d;
      err1_q       <= err1_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_logsin_q <= rsp_logsin_d;
      rsp_logcos_q <= rsp_logcos_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Driven from S1 only, so rsp_ready never reaches the LUT address combinationally.
  assign lut_addr   = (v1_q && !err1_q) ? addr1_q : 6'd0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_logsin = rsp_logsin_q;
  assign rsp_logcos = rsp_logcos_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = v1_q || rsp_valid_q;

endmodule

// File: tb/tb_log_trig_lut_arbiter.sv
// Cycle-by-cycle vector bench for log_trig_lut_arbiter with a small LUT model
// and a hand-written latency sequence.
module tb_log_trig_lut_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [17:0] req_addr;
  logic [2:0]  req_ready;
  logic [5:0]  lut_addr;
  logic [15:0] lut_logsin, lut_logcos;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_logsin, rsp_logcos;
  logic        rsp_err, busy;

  log_trig_lut_arbiter #(.NREQ(3), .IDW(2), .AMAX(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .lut_addr(lut_addr), .lut_logsin(lut_logsin), .lut_logcos(lut_logcos),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_logsin(rsp_logsin), .rsp_logcos(rsp_logcos), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference LUT: known points from the quarter-wave table, distinct filler elsewhere.
  always_comb begin
    case (lut_addr)
      6'd1:    begin lut_logsin = 16'hBA6A; lut_logcos = 16'hFFF9; end
      6'd8:    begin lut_logsin = 16'hE9D4; lut_logcos = 16'hFE2C; end
      6'd16:   begin lut_logsin = 16'hF800; lut_logcos = 16'hF800; end
      6'd24:   begin lut_logsin = 16'hFE2C; lut_logcos = 16'hE9D4; end
      6'd0,
      6'd32:   begin lut_logsin = 16'h0000; lut_logcos = 16'h0000; end
      default: begin lut_logsin = {10'h2A5, lut_addr}; lut_logcos = {10'h15A, lut_addr}; end
    endcase
  end

  typedef struct packed {
    logic [2:0]  ready;
    logic        rv;
    logic [1:0]  id;
    logic [15:0] sin;
    logic [15:0] cos;
    logic        err;
    logic        busy;
    logic [5:0]  lut;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [2:0] v;
    logic [5:0] a0, a1, a2;
    logic       rr;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n;

  function automatic void add(input logic r, input logic [2:0] v,
                              input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                              input logic rr, input logic [2:0] er, input logic rv,
                              input logic [1:0] id, input logic [15:0] s, input logic [15:0] c,
                              input logic e, input logic b, input logic [5:0] l);
    vec_t t;
    t.rst = r; t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.rr = rr;
    t.exp = '{ready: er, rv: rv, id: id, sin: s, cos: c, err: e, busy: b, lut: l};
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    obs_t act;

    // Single request, requester 1, addr 16.
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 3'b010, 0, 16, 0, 1, 3'b010, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 0, 0, 16'h0000, 16'h0000, 0, 1, 16);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 1, 1, 16'hF800, 16'hF800, 0, 1, 0);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 0, 1, 16'hF800, 16'hF800, 0, 0, 0);
    // Reset restores requester 0 priority, then a three-way stream.
    add(1, 3'b000, 0, 0, 0, 1,  3'b000, 0, 1, 16'hF800, 16'hF800, 0, 0, 0);
    add(0, 3'b111, 1, 8, 24, 1, 3'b001, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 3'b111, 1, 8, 24, 1, 3'b010, 0, 0, 16'h0000, 16'h0000, 0, 1, 1);
    add(0, 3'b111, 1, 8, 24, 1, 3'b100, 1, 0, 16'hBA6A, 16'hFFF9, 0, 1, 8);
    add(0, 3'b111, 1, 8, 24, 1, 3'b001, 1, 1, 16'hE9D4, 16'hFE2C, 0, 1, 24);
    add(0, 3'b111, 1, 8, 24, 1, 3'b010, 1, 2, 16'hFE2C, 16'hE9D4, 0, 1, 1);
    add(0, 3'b111, 1, 8, 24, 1, 3'b100, 1, 0, 16'hBA6A, 16'hFFF9, 0, 1, 8);
    // Five stalled cycles: everything holds, no grants.
    for (int i = 0; i < 5; i++)
      add(0, 3'b111, 1, 8, 24, 0, 3'b000, 1, 1, 16'hE9D4, 16'hFE2C, 0, 1, 24);
    add(0, 3'b111, 1, 8, 24, 1, 3'b001, 1, 1, 16'hE9D4, 16'hFE2C, 0, 1, 24);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 1, 2, 16'hFE2C, 16'hE9D4, 0, 1, 1);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 1, 0, 16'hBA6A, 16'hFFF9, 0, 1, 0);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 0, 0, 16'hBA6A, 16'hFFF9, 0, 0, 0);
    // Out-of-range index 40, then index 0.
    add(0, 3'b001, 40, 0, 0, 1, 3'b001, 0, 0, 16'hBA6A, 16'hFFF9, 0, 0, 0);
    add(0, 3'b001, 0, 0, 0, 1,  3'b001, 0, 0, 16'hBA6A, 16'hFFF9, 0, 1, 0);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 1, 0, 16'h0000, 16'h0000, 1, 1, 0);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 1, 0, 16'h0000, 16'h0000, 0, 1, 0);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    // Fairness: requester 2 alone (index 32), then 0 and 2 together.
    add(0, 3'b100, 0, 0, 32, 1, 3'b100, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 3'b101, 16, 0, 8, 1, 3'b001, 0, 0, 16'h0000, 16'h0000, 0, 1, 32);
    add(0, 3'b100, 0, 0, 8, 1,  3'b100, 1, 2, 16'h0000, 16'h0000, 0, 1, 16);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 1, 0, 16'hF800, 16'hF800, 0, 1, 8);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 1, 2, 16'hE9D4, 16'hFE2C, 0, 1, 0);
    // Fill both stages under backpressure, reset, then requester 0 wins first.
    add(0, 3'b111, 1, 8, 24, 1, 3'b001, 0, 2, 16'hE9D4, 16'hFE2C, 0, 0, 0);
    add(0, 3'b111, 1, 8, 24, 0, 3'b010, 0, 2, 16'hE9D4, 16'hFE2C, 0, 1, 1);
    add(0, 3'b111, 1, 8, 24, 0, 3'b000, 1, 0, 16'hBA6A, 16'hFFF9, 0, 1, 8);
    add(1, 3'b111, 1, 8, 24, 0, 3'b000, 1, 0, 16'hBA6A, 16'hFFF9, 0, 1, 8);
    add(0, 3'b111, 1, 8, 24, 1, 3'b001, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 0, 0, 16'h0000, 16'h0000, 0, 1, 1);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 1, 0, 16'hBA6A, 16'hFFF9, 0, 1, 0);
    add(0, 3'b000, 0, 0, 0, 1,  3'b000, 0, 0, 16'hBA6A, 16'hFFF9, 0, 0, 0);

    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst       = vecs[k].rst;
      req_valid = vecs[k].v;
      req_addr  = {vecs[k].a2, vecs[k].a1, vecs[k].a0};
      rsp_ready = vecs[k].rr;
      #1;
      act = {req_ready, rsp_valid, rsp_id, rsp_logsin, rsp_logcos, rsp_err, busy, lut_addr};
      check($sformatf("vec%0d", k), 64'(act), 64'(vecs[k].exp));
    end

    // Hand-written: requester 1 asks for index 8; response must land two cycles later.
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 3'b010;
    req_addr  = {6'd0, 6'd8, 6'd0};
    rsp_ready = 1'b1;
    #1;
    check("seq_grant", 64'(req_ready), 64'(3'b010));
    @(negedge clk);
    req_valid = '0;
    #1;
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("seq_latency", 64'(n), 64'd2);
    check("seq_data", 64'({rsp_valid, rsp_id, rsp_logsin, rsp_logcos, rsp_err}),
          64'({1'b1, 2'd1, 16'hE9D4, 16'hFE2C, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
